// File: rtl/pingpong_wr_ctrl_pkg.sv
// Shared definitions for the ping-pong frame buffer write-side controller.
// State encoding and the bank base-address helper.
package pingpong_wr_ctrl_pkg;

   typedef enum logic {
      WAIT_SOF = 1'b0,
      WRITE    = 1'b1
   } wr_state_t;

   // Base pixel index of a bank; banks are FRAME_PIXELS apart, not a power of 2.
   function automatic int unsigned bank_base(input logic bank, input int unsigned frame_pixels);
      return bank ? frame_pixels : 0;
   endfunction

endpackage

// File: rtl/pingpong_wr_ctrl_sync_toggle_edge.sv
// Two-flop synchronizer plus edge detector for a toggle crossing into i_clk.
// o_edge is a one-cycle pulse per toggle of i_tgl.
module sync_toggle_edge (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_tgl,
   output logic o_edge
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= i_tgl;
         sync <= meta;
         prev <= sync;
      end
   end

   assign o_edge = sync ^ prev;

endmodule

// File: rtl/pingpong_wr_ctrl.sv
// Write-side controller of the ping-pong frame buffer: writes whole frames
// alternately into two BRAM banks and hands completed frames to the read side.
module pingpong_wr_ctrl
   import pingpong_wr_ctrl_pkg::*;
#(
   parameter  int PIXEL_WIDTH  = 12,
   parameter  int FRAME_PIXELS = 76800,
   localparam int AW           = $clog2(2 * FRAME_PIXELS)
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   input  logic                   i_valid,
   input  logic                   i_sof,
   input  logic [PIXEL_WIDTH-1:0] i_data,
   input  logic                   i_rd_done_tgl,
   output logic                   o_wportEn,
   output logic                   o_wr,
   output logic [AW-1:0]          o_waddr,
   output logic [PIXEL_WIDTH-1:0] o_wdata,
   output logic                   o_frame_done_tgl,
   output logic [1:0]             o_bank_full,
   output logic                   o_drop,
   output logic                   o_sync_err
);

   wr_state_t     state;
   wr_state_t     state_nxt;
   logic          wr_bank;
   logic          rd_ptr;
   logic [AW-1:0] idx;
   logic [AW-1:0] idx_nxt;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] bank_addr;
   logic [1:0]    full_nxt;
   logic          accept;
   logic          restart;
   logic          drop;
   logic          sync_err;
   logic          last;
   logic          rel;

   sync_toggle_edge u_rd_done_sync (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_tgl  (i_rd_done_tgl),
      .o_edge (rel)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state <= WAIT_SOF;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_SOF: if (accept && !last) state_nxt = WRITE;
         WRITE:    if (last)            state_nxt = WAIT_SOF;
         default:  state_nxt = WAIT_SOF;
      endcase
   end

   always_comb begin
      accept   = 1'b0;
      restart  = 1'b0;
      drop     = 1'b0;
      sync_err = 1'b0;
      case (state)
         WAIT_SOF: begin
            if (i_valid && i_sof) begin
               if (!o_bank_full[wr_bank]) begin
                  accept  = 1'b1;
                  restart = 1'b1;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         WRITE: begin
            if (i_valid) begin
               accept = 1'b1;
               if (i_sof) begin
                  restart  = 1'b1;
                  sync_err = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // A restart (sof) always lands at index 0 of the current bank.
   always_comb begin
      wr_idx    = restart ? '0 : idx;
      last      = accept && (wr_idx == AW'(FRAME_PIXELS - 1));
      bank_addr = AW'(bank_base(wr_bank, FRAME_PIXELS));
      idx_nxt   = idx;
      if (accept) idx_nxt = last ? '0 : wr_idx + 1'b1;
      full_nxt = o_bank_full;
      if (rel)  full_nxt[rd_ptr]  = 1'b0;
      if (last) full_nxt[wr_bank] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_wportEn        <= 1'b0;
         o_wr             <= 1'b0;
         o_waddr          <= '0;
         o_wdata          <= '0;
         o_frame_done_tgl <= 1'b0;
         o_bank_full      <= 2'b00;
         o_drop           <= 1'b0;
         o_sync_err       <= 1'b0;
         wr_bank          <= 1'b0;
         rd_ptr           <= 1'b0;
         idx              <= '0;
      end else begin
         o_wportEn   <= accept;
         o_wr        <= accept;
         o_drop      <= drop;
         o_sync_err  <= sync_err;
         o_bank_full <= full_nxt;
         idx         <= idx_nxt;
         if (accept) begin
            o_waddr <= bank_addr + wr_idx;
            o_wdata <= i_data;
         end
         if (last) begin
            wr_bank          <= ~wr_bank;
            o_frame_done_tgl <= ~o_frame_done_tgl;
         end
         if (rel) rd_ptr <= ~rd_ptr;
      end
   end

endmodule

// File: doc/pingpong_wr_ctrl.md
Name: pingpong_wr_ctrl

Overview:
Single-clock write-side controller for the ping-pong frame buffer. It accepts a camera pixel stream and writes whole frames alternately into bank 0 or bank 1 of the dual-clock BRAM. It tracks bank ownership and hands each completed frame to the read domain through a toggle. It never overwrites a bank that the read side has not yet released.

Parameters:
- PIXEL_WIDTH, 12, pixel data width; equals the BRAM width.
- FRAME_PIXELS, 76800, pixels per frame, which is also the bank size. BRAM depth = 2*FRAME_PIXELS (153600).
- AW, $clog2(2*FRAME_PIXELS), BRAM address width; derived, not overridden.

Ports:
- i_clk  in  1  write-domain clock.
- i_rstn  in  1  asynchronous, active-low reset.
- i_valid  in  1  pixel valid. There is no backpressure.
- i_sof  in  1  start of frame; qualified by i_valid and marks the first pixel.
- i_data  in  PIXEL_WIDTH  pixel value.
- i_rd_done_tgl  in  1  read-domain toggle: one edge per bank released. Asynchronous to i_clk.
- o_wportEn  out  1  BRAM write-port enable.
- o_wr  out  1  BRAM write strobe.
- o_waddr  out  AW  BRAM write address.
- o_wdata  out  PIXEL_WIDTH  BRAM write data.
- o_frame_done_tgl  out  1  toggles once per completed frame; crosses to the read domain.
- o_bank_full  out  2  per-bank full flags.
- o_drop  out  1  one-cycle pulse when a valid pixel is discarded because no bank is free.
- o_sync_err  out  1  one-cycle pulse when i_sof arrives mid-frame.

Behaviour:
- Reset (asynchronous assert, synchronous release) sets:
  - all outputs to 0, o_bank_full=2'b00;
  - wr_bank=0, rd_ptr=0, idx=0, state=WAIT_SOF;
  - synchronizer flops to 0.
- i_rd_done_tgl passes through a 2-flop synchronizer plus an edge-detect flop. Each detected edge clears o_bank_full[rd_ptr] and flips rd_ptr. Latency is 3 cycles from the input edge to the flag clear.
- Address: o_waddr = (wr_bank ? FRAME_PIXELS : 0) + idx. Use an adder, not bank concatenation, because FRAME_PIXELS need not be a power of 2.
- Write path is registered, 1-cycle latency. For an accepted pixel in cycle N, o_wportEn=o_wr=1 in cycle N+1, with o_waddr and o_wdata from cycle N. Otherwise o_wportEn=o_wr=0; o_waddr and o_wdata hold their previous values.
- State machine:
  - WAIT_SOF: a pixel with i_valid & i_sof is handled as follows.
    - If o_bank_full[wr_bank]=0: accept it at idx 0, set idx=1, go to WRITE.
    - Otherwise: pulse o_drop and stay in WAIT_SOF.
    - A valid pixel without i_sof is silently discarded (no o_drop).
  - WRITE: each i_valid pixel is accepted at the current idx and idx increments.
    - Last pixel (idx==FRAME_PIXELS-1 when accepted): set o_bank_full[wr_bank], toggle o_frame_done_tgl, flip wr_bank, clear idx, go to WAIT_SOF.
    - i_valid & i_sof while in WRITE: pulse o_sync_err, restart the same bank, write that pixel at idx 0, set idx=1, stay in WRITE. The bank is not marked full.
- Simultaneous frame completion and read-release edge in the same cycle:
  - both updates apply;
  - the set applies to wr_bank and the clear to rd_ptr; these differ by construction.
  - If they are equal, the set wins.
- The read release for a bank that is not full is ignored, and rd_ptr still flips. This is a protocol violation and is flagged by an assertion in the bench.
- o_frame_done_tgl toggles in the same cycle that o_bank_full is set. The read side samples it through its own synchronizer.
- Reset mid-frame discards the partial frame. The BRAM contents are left untouched.

Decomposition:
- Shared package: state encoding typedef (WAIT_SOF, WRITE) and a bank-index constant helper.
- One natural sub-module, sync_toggle_edge. It holds the 2-flop synchronizer and edge detector, and is reused by the read-side controller for o_frame_done_tgl.

Test Plan (FRAME_PIXELS=8 for simulation):
1. Reset, then sof plus 8 pixels with data 0..7.
   - Writes go to addresses 0..7, each one cycle after its input.
   - After the last pixel: o_bank_full=01, o_frame_done_tgl=1.
2. A second frame with data 8..15 goes to addresses 8..15. Then o_bank_full=11 and o_frame_done_tgl=0.
3. A third sof while o_bank_full=11 gives an o_drop pulse and no o_wr. Toggle i_rd_done_tgl once; 3 cycles later o_bank_full=10. The next frame then writes addresses 0..7.
4. sof, 3 pixels, then sof again.
   - o_sync_err pulses.
   - The restart pixel is written at address 0 of the same bank.
   - o_bank_full stays unchanged until 8 more pixels complete.
5. A valid pixel with no sof in WAIT_SOF produces no write and no o_drop.
6. Assert i_rstn low at pixel 5 of a frame.
   - All outputs go to 0 immediately.
   - After release, the next frame writes from address 0.
